bus_xfer_scheduler: RTL and testbench

Queues register-to-register transfer requests and sequences the shared 24-bit source MUX, one transfer per cycle. For each transfer it drives the MUX select, then asserts the one-hot write-enable of the destination register in the cycle the registered MUX output is valid. It sits between the control unit, which issues transfers, and the MUX/register file.

---
 rtl/bus_sched_pkg.sv | 42 ++++
 rtl/bus_xfer_scheduler_xfer_fifo.sv | 88 ++++++++
 rtl/bus_xfer_scheduler.sv | 159 +++++++++++++++
 tb/tb_bus_xfer_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sched_pkg.sv
// ----------------------------------------------------------------------------
// bus_sched_pkg
//
// Shared definitions for the bus transfer scheduler:
//   - MUX source codes and the idle select driven when no transfer is issued
//   - src_legal(): tells whether a source code selects a real MUX input
//   - the request record pushed into the request FIFO (default geometry:
//     3-bit source code, 3-bit destination index)
// ----------------------------------------------------------------------------
package bus_sched_pkg;

   localparam int SRC_CODE_W = 3;
   localparam int DST_IDX_W  = 3;

   localparam logic [SRC_CODE_W-1:0] SRC_L    = 3'b111;
   localparam logic [SRC_CODE_W-1:0] SRC_W    = 3'b010;
   localparam logic [SRC_CODE_W-1:0] SRC_K    = 3'b011;
   localparam logic [SRC_CODE_W-1:0] SRC_T    = 3'b001;
   localparam logic [SRC_CODE_W-1:0] SRC_X    = 3'b101;
   localparam logic [SRC_CODE_W-1:0] SRC_J    = 3'b110;

   // L is the harmless default: the MUX parks on it whenever nothing issues.
   localparam logic [SRC_CODE_W-1:0] SRC_IDLE = SRC_L;

   typedef struct packed {
      logic [SRC_CODE_W-1:0] src;
      logic [DST_IDX_W-1:0]  dst;
   } xfer_req_t;

   localparam int XFER_REQ_W = $bits(xfer_req_t);

   // Codes 000 and 100 select no MUX input.
   function automatic logic src_legal(input logic [SRC_CODE_W-1:0] src);
      logic legal;
      case (src)
         SRC_L, SRC_W, SRC_K, SRC_T, SRC_X, SRC_J: legal = 1'b1;
         default:                                  legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage : bus_sched_pkg

// File: rtl/bus_xfer_scheduler_xfer_fifo.sv
// ----------------------------------------------------------------------------
// xfer_fifo
//
// Synchronous first-word-fall-through FIFO with asynchronous active-low reset.
// The head entry is always visible on rd_data while the FIFO is non-empty.
//
// Ports:
//   clk, rst_n      clock (rising edge) and async active-low reset
//   push, wr_data   write an entry; ignored when full
//   pop             remove the head entry; ignored when empty
//   rd_data         current head entry
//   full, empty     occupancy flags, decoded from count
//   count           number of stored entries (0..DEPTH)
//
// Push and pop in the same cycle both take effect; count is unchanged.
// Pointers are PTR_W wide, so they wrap modulo DEPTH (DEPTH is a power of 2).
// ----------------------------------------------------------------------------
module xfer_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule : xfer_fifo

// File: rtl/bus_xfer_scheduler.sv
// ----------------------------------------------------------------------------
// bus_xfer_scheduler
//
// Queues register-to-register transfer requests from the control unit and
// sequences the shared 24-bit source MUX, one transfer per cycle.
//
// Ports:
//   clk, rst_n   clock (rising edge) and async active-low reset
//   req_valid    request valid from the control unit
//   req_ready    FIFO can accept (= !full, combinational)
//   req_src      MUX source code of the request
//   req_dst      destination register index
//   bus_hold     freeze issue of new transfers
//   mux_sel      registered MUX select (L when idle)
//   dst_we       registered one-hot destination write-enable
//   xfer_done    one-cycle pulse coincident with dst_we
//   src_err      one-cycle pulse when an illegal entry is issued
//   busy         FIFO non-empty or a transfer in flight
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on FIFO fullness, never on
// a pop in the same cycle, so a full FIFO refuses even while draining; the
// requester keeps req_valid and the payload stable until it is accepted.
//
// Pipeline (edges E0..E3 for one request):
//   E0  request pushed into the FIFO
//   E1  issue: head popped, mux_sel loaded, stage 1 holds the destination
//   E2  stage 2: dst_we/xfer_done asserted while the MUX output register holds
//       the selected source
//   E3  destination register captures the MUX output
// ----------------------------------------------------------------------------
module bus_xfer_scheduler
   import bus_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int NDST  = 8,
   parameter int SEL_W = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [SEL_W-1:0]        req_src,
   input  logic [$clog2(NDST)-1:0] req_dst,
   input  logic                    bus_hold,
   output logic [SEL_W-1:0]        mux_sel,
   output logic [NDST-1:0]         dst_we,
   output logic                    xfer_done,
   output logic                    src_err,
   output logic                    busy
);

   localparam int DST_W = $clog2(NDST);
   localparam int REQ_W = SEL_W + DST_W;
   localparam int CNT_W = $clog2(DEPTH + 1);

   // ---------------------------------------------------------------------
   // Request FIFO
   // ---------------------------------------------------------------------
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [REQ_W-1:0] fifo_wdata;
   logic [REQ_W-1:0] fifo_rdata;

   assign req_ready  = ~fifo_full;
   assign fifo_push  = req_valid & req_ready;
   assign fifo_wdata = {req_src, req_dst};

   xfer_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REQ_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (fifo_push),
      .wr_data (fifo_wdata),
      .pop     (fifo_pop),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // ---------------------------------------------------------------------
   // Issue decision on the FIFO head
   // ---------------------------------------------------------------------
   logic [SEL_W-1:0] head_src;
   logic [DST_W-1:0] head_dst;
   logic             head_legal;

   assign {head_src, head_dst} = fifo_rdata;

   // Illegal entries still pop so a bad request cannot wedge the queue.
   assign fifo_pop   = ~fifo_empty & ~bus_hold;
   assign head_legal = src_legal(head_src) && (int'(head_dst) < NDST);

   // ---------------------------------------------------------------------
   // Stage 1 (issue) and stage 2 (writeback) registers
   // ---------------------------------------------------------------------
   logic [SEL_W-1:0] mux_sel_q,  mux_sel_d;
   logic             s1_valid_q, s1_valid_d;
   logic [DST_W-1:0] s1_dst_q,   s1_dst_d;
   logic             src_err_q,  src_err_d;
   logic             s2_valid_q, s2_valid_d;
   logic [NDST-1:0]  dst_we_q,   dst_we_d;

   always_comb begin
      // Idle default: park the MUX on L and let stage 1 go empty.
      mux_sel_d  = SEL_W'(SRC_IDLE);
      s1_valid_d = 1'b0;
      s1_dst_d   = s1_dst_q;
      src_err_d  = 1'b0;

      if (fifo_pop) begin
         s1_dst_d   = head_dst;
         s1_valid_d = head_legal;
         src_err_d  = ~head_legal;
         if (head_legal) begin
            mux_sel_d = head_src;
         end
      end

      // Stage 2 follows stage 1 unconditionally: bus_hold only blocks issue,
      // so a transfer already selected on the MUX always finishes its write.
      s2_valid_d = s1_valid_q;
      dst_we_d   = '0;
      if (s1_valid_q) begin
         dst_we_d[s1_dst_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_sel_q  <= SEL_W'(SRC_IDLE);
         s1_valid_q <= 1'b0;
         s1_dst_q   <= '0;
         src_err_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         dst_we_q   <= '0;
      end else begin
         mux_sel_q  <= mux_sel_d;
         s1_valid_q <= s1_valid_d;
         s1_dst_q   <= s1_dst_d;
         src_err_q  <= src_err_d;
         s2_valid_q <= s2_valid_d;
         dst_we_q   <= dst_we_d;
      end
   end

   assign mux_sel   = mux_sel_q;
   assign dst_we    = dst_we_q;
   assign xfer_done = s2_valid_q;
   assign src_err   = src_err_q;
   assign busy      = (fifo_count != '0) | s1_valid_q | s2_valid_q;

endmodule : bus_xfer_scheduler

// File: tb/tb_bus_xfer_scheduler.sv
// ----------------------------------------------------------------------------
// tb_bus_xfer_scheduler
//
// Directed bench for bus_xfer_scheduler. A small environment model stands in
// for the MUX (registered 24-bit output) and the destination register file so
// the written data can be checked end to end.
// ----------------------------------------------------------------------------
module tb_bus_xfer_scheduler;

   localparam int DEPTH = 4;
   localparam int NDST  = 8;
   localparam int SEL_W = 3;
   localparam int DST_W = 3;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [SEL_W-1:0] req_src;
   logic [DST_W-1:0] req_dst;
   logic             bus_hold;
   logic [SEL_W-1:0] mux_sel;
   logic [NDST-1:0]  dst_we;
   logic             xfer_done;
   logic             src_err;
   logic             busy;

   int n_vec;
   int n_err;

   // ---------------------------------------------------------------------
   // Clock and DUT
   // ---------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   bus_xfer_scheduler #(
      .DEPTH (DEPTH),
      .NDST  (NDST),
      .SEL_W (SEL_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_src   (req_src),
      .req_dst   (req_dst),
      .bus_hold  (bus_hold),
      .mux_sel   (mux_sel),
      .dst_we    (dst_we),
      .xfer_done (xfer_done),
      .src_err   (src_err),
      .busy      (busy)
   );

   // ---------------------------------------------------------------------
   // Environment: MUX sources, registered MUX output, register file
   // ---------------------------------------------------------------------
   logic        clr_regs;
   logic [23:0] mux_q;
   logic [23:0] regs [NDST];

   function automatic logic [23:0] mux_val(input logic [2:0] s);
      case (s)
         3'b111:  return 24'h000111;
         3'b010:  return 24'd256;
         3'b011:  return 24'h000333;
         3'b001:  return 24'h000444;
         3'b101:  return 24'h000555;
         3'b110:  return 24'h000666;
         default: return 24'h00dead;
      endcase
   endfunction

   always @(posedge clk) begin
      mux_q <= mux_val(mux_sel);
      for (int i = 0; i < NDST; i++) begin
         if (clr_regs)       regs[i] <= '0;
         else if (dst_we[i]) regs[i] <= mux_q;
      end
   end

   // Advance one rising edge and settle away from it.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_regs;
      clr_regs = 1'b1;
      tick();
      clr_regs = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------
   task automatic test_reset;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_src   = '0;
      req_dst   = '0;
      bus_hold  = 1'b0;
      clr_regs  = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst_n    = 1'b1;
      clr_regs = 1'b0;
      tick();
      n_vec++; if (mux_sel !== 3'b111) begin n_err++; $display("FAIL reset_mux_sel got %b want 111", mux_sel); end
      n_vec++; if (dst_we !== 8'h00) begin n_err++; $display("FAIL reset_dst_we got %h want 00", dst_we); end
      n_vec++; if (xfer_done !== 1'b0 || src_err !== 1'b0) begin n_err++; $display("FAIL reset_pulses done=%b err=%b want 0 0", xfer_done, src_err); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
   endtask

   task automatic test_single;
      clear_regs();
      req_valid = 1'b1; req_src = 3'b010; req_dst = 3'd3;
      tick();  // E0: accepted
      req_valid = 1'b0;
      n_vec++; if (mux_sel !== 3'b111 || busy !== 1'b1) begin n_err++; $display("FAIL single_e0 mux_sel=%b busy=%b want 111 1", mux_sel, busy); end
      tick();  // E1: issued
      n_vec++; if (mux_sel !== 3'b010) begin n_err++; $display("FAIL single_e1_mux_sel got %b want 010", mux_sel); end
      n_vec++; if (dst_we !== 8'h00) begin n_err++; $display("FAIL single_e1_dst_we got %h want 00", dst_we); end
      tick();  // E2: write enable
      n_vec++; if (dst_we !== 8'b0000_1000 || xfer_done !== 1'b1) begin n_err++; $display("FAIL single_e2_we dst_we=%b done=%b want 00001000 1", dst_we, xfer_done); end
      n_vec++; if (mux_sel !== 3'b111 || busy !== 1'b1) begin n_err++; $display("FAIL single_e2_state mux_sel=%b busy=%b want 111 1", mux_sel, busy); end
      tick();  // E3: register captures
      n_vec++; if (dst_we !== 8'h00 || xfer_done !== 1'b0) begin n_err++; $display("FAIL single_e3_we dst_we=%h done=%b want 00 0", dst_we, xfer_done); end
      n_vec++; if (regs[3] !== 24'd256) begin n_err++; $display("FAIL single_reg3 got %0d want 256", regs[3]); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall got %b want 0", busy); end
   endtask

   task automatic test_burst;
      logic [2:0]  srcs [6];
      logic [23:0] exp_v [6];
      int p, k, first_c, last_c;
      logic acc;
      srcs[0] = 3'b111; srcs[1] = 3'b010; srcs[2] = 3'b011;
      srcs[3] = 3'b001; srcs[4] = 3'b101; srcs[5] = 3'b110;
      exp_v[0] = 24'h000111; exp_v[1] = 24'd256;     exp_v[2] = 24'h000333;
      exp_v[3] = 24'h000444; exp_v[4] = 24'h000555; exp_v[5] = 24'h000666;
      clear_regs();
      // Hold issue so the FIFO fills.
      bus_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_src = srcs[i]; req_dst = 3'(i);
         tick();
      end
      p = 4; k = 0; first_c = -1; last_c = -1;
      req_src = srcs[4]; req_dst = 3'd4;
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL burst_full_ready got %b want 0", req_ready); end
      bus_hold = 1'b0;
      for (int c = 0; c < 20; c++) begin
         req_valid = (p < 6);
         if (p < 6) begin req_src = srcs[p]; req_dst = 3'(p); end
         acc = req_valid & req_ready;
         tick();
         if (acc) p++;
         n_vec++;
         if ((dst_we !== 8'h00) !== xfer_done) begin n_err++; $display("FAIL burst_we_done_align cycle %0d dst_we=%h done=%b", c, dst_we, xfer_done); end
         if (xfer_done === 1'b1) begin
            n_vec++;
            if (k >= 6 || dst_we !== 8'(1 << k)) begin n_err++; $display("FAIL burst_order xfer %0d dst_we=%h want %h", k, dst_we, 8'(1 << k)); end
            if (first_c < 0) first_c = c;
            last_c = c;
            k++;
         end
      end
      req_valid = 1'b0;
      n_vec++; if (k !== 6 || p !== 6) begin n_err++; $display("FAIL burst_count done=%0d pushed=%0d want 6 6", k, p); end
      n_vec++; if (last_c - first_c !== 5) begin n_err++; $display("FAIL burst_consecutive span=%0d want 5", last_c - first_c); end
      for (int i = 0; i < 6; i++) begin
         n_vec++; if (regs[i] !== exp_v[i]) begin n_err++; $display("FAIL burst_reg%0d got %h want %h", i, regs[i], exp_v[i]); end
      end
   endtask

   task automatic test_illegal;
      logic [2:0] srcs [3];
      logic [2:0] dsts [3];
      int p, errs, dones;
      logic acc;
      srcs[0] = 3'b000; dsts[0] = 3'd1;
      srcs[1] = 3'b100; dsts[1] = 3'd2;
      srcs[2] = 3'b010; dsts[2] = 3'd6;
      clear_regs();
      p = 0; errs = 0; dones = 0;
      for (int c = 0; c < 12; c++) begin
         req_valid = (p < 3);
         if (p < 3) begin req_src = srcs[p]; req_dst = dsts[p]; end
         acc = req_valid & req_ready;
         tick();
         if (acc) p++;
         if (src_err === 1'b1) begin
            errs++;
            n_vec++; if (mux_sel !== 3'b111) begin n_err++; $display("FAIL illegal_mux_sel got %b want 111", mux_sel); end
         end
         if (xfer_done === 1'b1) begin
            dones++;
            n_vec++; if (dst_we !== 8'h40) begin n_err++; $display("FAIL illegal_follow_we got %h want 40", dst_we); end
         end
      end
      req_valid = 1'b0;
      n_vec++; if (errs !== 2) begin n_err++; $display("FAIL illegal_err_count got %0d want 2", errs); end
      n_vec++; if (dones !== 1) begin n_err++; $display("FAIL illegal_done_count got %0d want 1", dones); end
      n_vec++; if (regs[1] !== 24'd0 || regs[2] !== 24'd0) begin n_err++; $display("FAIL illegal_no_write r1=%h r2=%h want 0 0", regs[1], regs[2]); end
      n_vec++; if (regs[6] !== 24'd256) begin n_err++; $display("FAIL illegal_follow_reg6 got %0d want 256", regs[6]); end
   endtask

   task automatic test_hold;
      clear_regs();
      req_valid = 1'b1; req_src = 3'b011; req_dst = 3'd2;
      tick();  // A accepted
      req_src = 3'b001; req_dst = 3'd4;
      tick();  // A issued, B accepted
      n_vec++; if (mux_sel !== 3'b011) begin n_err++; $display("FAIL hold_a_issue got %b want 011", mux_sel); end
      req_src = 3'b101; req_dst = 3'd5; bus_hold = 1'b1;
      tick();  // first held edge: A writes, C accepted
      req_valid = 1'b0;
      n_vec++; if (dst_we !== 8'h04 || xfer_done !== 1'b1) begin n_err++; $display("FAIL hold_inflight_we dst_we=%h done=%b want 04 1", dst_we, xfer_done); end
      n_vec++; if (mux_sel !== 3'b111) begin n_err++; $display("FAIL hold_mux_idle0 got %b want 111", mux_sel); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++; if (mux_sel !== 3'b111 || dst_we !== 8'h00 || busy !== 1'b1) begin n_err++; $display("FAIL hold_frozen cycle %0d mux_sel=%b dst_we=%h busy=%b want 111 00 1", i, mux_sel, dst_we, busy); end
      end
      n_vec++; if (regs[2] !== 24'h000333) begin n_err++; $display("FAIL hold_reg2 got %h want 000333", regs[2]); end
      bus_hold = 1'b0;
      tick();
      n_vec++; if (mux_sel !== 3'b001) begin n_err++; $display("FAIL hold_release_b got %b want 001", mux_sel); end
      tick();
      n_vec++; if (mux_sel !== 3'b101 || dst_we !== 8'h10) begin n_err++; $display("FAIL hold_release_c mux_sel=%b dst_we=%h want 101 10", mux_sel, dst_we); end
      tick();
      n_vec++; if (dst_we !== 8'h20 || mux_sel !== 3'b111) begin n_err++; $display("FAIL hold_release_cw dst_we=%h mux_sel=%b want 20 111", dst_we, mux_sel); end
      tick();
      n_vec++; if (regs[4] !== 24'h000444 || regs[5] !== 24'h000555 || busy !== 1'b0) begin n_err++; $display("FAIL hold_final r4=%h r5=%h busy=%b want 000444 000555 0", regs[4], regs[5], busy); end
   endtask

   task automatic test_full_retry;
      int dones;
      logic [NDST-1:0] last_we;
      logic acc;
      clear_regs();
      bus_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_src = 3'b010; req_dst = 3'(i);
         tick();
      end
      req_src = 3'b011; req_dst = 3'd4;  // request E held valid while full
      bus_hold = 1'b0;
      // Head pops on the coming edge, but the full FIFO must still refuse.
      acc = req_valid & req_ready;
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_during_pop got %b want 0", req_ready); end
      tick();
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after_pop got %b want 1", req_ready); end
      acc = req_valid & req_ready;
      tick();  // E accepted here
      req_valid = 1'b0;
      n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL full_retry_accept got %b want 1", acc); end
      dones = 0; last_we = '0;
      if (xfer_done === 1'b1) begin dones++; last_we = dst_we; end
      for (int c = 0; c < 12; c++) begin
         tick();
         if (xfer_done === 1'b1) begin dones++; last_we = dst_we; end
      end
      n_vec++; if (dones !== 5) begin n_err++; $display("FAIL full_done_count got %0d want 5", dones); end
      n_vec++; if (last_we !== 8'h10) begin n_err++; $display("FAIL full_last_we got %h want 10", last_we); end
      n_vec++; if (regs[4] !== 24'h000333 || regs[0] !== 24'd256) begin n_err++; $display("FAIL full_regs r4=%h r0=%h want 000333 000100", regs[4], regs[0]); end
   endtask

   task automatic test_async_reset;
      int bad;
      clear_regs();
      req_valid = 1'b1; req_src = 3'b010; req_dst = 3'd7;
      tick();  // E0
      req_valid = 1'b0;
      tick();  // E1
      n_vec++; if (mux_sel !== 3'b010) begin n_err++; $display("FAIL arst_e1_mux_sel got %b want 010", mux_sel); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (mux_sel !== 3'b111 || dst_we !== 8'h00) begin n_err++; $display("FAIL arst_immediate mux_sel=%b dst_we=%h want 111 00", mux_sel, dst_we); end
      n_vec++; if (xfer_done !== 1'b0 || src_err !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL arst_flags done=%b err=%b busy=%b ready=%b want 0 0 0 1", xfer_done, src_err, busy, req_ready); end
      tick();
      #2 rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (dst_we !== 8'h00 || xfer_done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) bad++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL arst_quiet %0d cycles with activity, want 0", bad); end
      n_vec++; if (regs[7] !== 24'd0) begin n_err++; $display("FAIL arst_no_write reg7=%h want 0", regs[7]); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_single();
      test_burst();
      test_illegal();
      test_hold();
      test_full_retry();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_bus_xfer_scheduler
